fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Program counter / instruction fetch stage of the 9-bit processor.
//   - Drives the instruction ROM address and sequences execution from Start to Done.
//   - Consumes jump_en, branch_en and halt from the control decoder, plus target bits instr[4:0].
//   - Provides a run-cycle counter for benchmarking.
// PARAMETERS
//   PC_W        10    program counter / ROM address width
//   START_ADDR  0     PC value loaded at reset and on Start
//   MAX_ADDR    1023  last valid program address; sequential fetch past it ends the run
//   CNT_W       16    width of cycle_count
// PORTS
//   Clk          in   1      single clock; all state updates on rising edge
//   Reset        in   1      synchronous, active-high reset
//   Start        in   1      one-cycle pulse: begin a run from START_ADDR
//   Halt         in   1      decoder saw halt instruction at current PC
//   jump_en      in   1      unconditional redirect from decoder
//   branch_en    in   1      taken branch from decoder (already qualified with ZERO)
//   target_idx   in   5      instr[4:0]: signed offset or LUT index
//   lut_we       in   1      LUT write enable (used only with JUMP_LUT_EN)
//   lut_waddr    in   5      LUT write index
//   lut_wdata    in   PC_W   LUT write data
//   PC           out  PC_W   instruction ROM address
//   fetch_valid  out  1      PC holds a live instruction (high only in RUN)
//   Done         out  1      run finished; held until next Start
//   cycle_count  out  CNT_W  cycles spent in RUN for the last/current run
// BEHAVIOUR
//   Reset (on any edge with Reset=1, including mid-run):
//     state=IDLE, PC=START_ADDR, fetch_valid=0, Done=0, cycle_count=0.
//   FSM states IDLE, RUN, DONE; outputs are registered.
//   IDLE
//     - PC held; Start=1 -> RUN, PC=START_ADDR, cycle_count=0.
//   RUN
//     - fetch_valid=1; cycle_count += 1 every RUN cycle, saturating at all-ones.
//     - Next PC, priority high->low:
//       1. Halt -> DONE, PC held, Done=1 next cycle.
//       2. jump_en -> PC = target.
//       3. branch_en -> PC = target.
//       4. PC == MAX_ADDR -> DONE, PC held.
//       5. else PC = PC+1.
//     - jump_en and branch_en together: treated as jump (same target).
//     - Redirect to target takes effect on the next edge (1-cycle latency, no bubble).
//     - Start while in RUN is ignored.
//   Target arithmetic (macro absent)
//     - target = PC + sext(target_idx), modulo 2^PC_W.
//     - Wraps silently, e.g. PC=1, offset -3 -> 2^PC_W-2.
//   DONE
//     - Done=1, fetch_valid=0, PC and cycle_count held.
//     - Start=1 -> RUN: PC=START_ADDR, cycle_count=0, Done=0 on the next cycle.
//   Halt/jump/branch inputs are ignored outside RUN.
// CONFIGURATION
//   JUMP_LUT_EN defined
//     - Adds a 32 x PC_W target LUT; target = lut[target_idx] (absolute address).
//     - LUT writes are synchronous and accepted in any state.
//     - Write and read of the same index in one cycle returns the old value.
//     - Reset clears all entries to 0.
//   JUMP_LUT_EN undefined
//     - No LUT storage; lut_* ports present but ignored; relative targets as above.
// TESTING
//   1. Reset, Start pulse, no redirects -> PC 0,1,2,3..., fetch_valid=1 from first RUN cycle, Done=0.
//   2. Relative: PC=10, branch_en=1, target_idx=5'b11101 -> next PC=7; branch_en=0 -> PC=8.
//   3. Halt=1 and jump_en=1 at PC=4 (started at 0) -> DONE, PC stays 4, Done=1, cycle_count=5.
//   4. MAX_ADDR=12, no redirects -> PC stops at 12, DONE next cycle; Start then restarts at PC=0, count=0.
//   5. JUMP_LUT_EN: write lut[3]=200, then jump_en with target_idx=3 -> next PC=200.
//      Same-cycle write lut[3]=50 with jump idx 3 still -> 200.
//   6. Reset at PC=9 during RUN -> next cycle IDLE, PC=0, Done=0, fetch_valid=0, cycle_count=0;
//      Start required to resume.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch-stage bus: decoder/controller side (master) drives Start, Halt,
// redirects, target index and LUT writes; the fetch unit (slave) returns
// the PC, fetch_valid, Done and the run-cycle counter.
interface fetch_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Halt;
  logic             jump_en;
  logic             branch_en;
  logic [4:0]       target_idx;
  logic             lut_we;
  logic [4:0]       lut_waddr;
  logic [PC_W-1:0]  lut_wdata;
  logic [PC_W-1:0]  PC;
  logic             fetch_valid;
  logic             Done;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output Start, Halt, jump_en, branch_en, target_idx,
           lut_we, lut_waddr, lut_wdata,
    input  PC, fetch_valid, Done, cycle_count
  );

  modport slave (
    input  Start, Halt, jump_en, branch_en, target_idx,
           lut_we, lut_waddr, lut_wdata,
    output PC, fetch_valid, Done, cycle_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Program counter / instruction fetch stage of the 9-bit processor.
// Sequences a run IDLE -> RUN -> DONE, redirects on jump/branch, stops on
// halt or when sequential fetch reaches MAX_ADDR, and counts RUN cycles.
// Optional feature: define JUMP_LUT_EN to replace PC-relative targets with
// a 32-entry absolute target LUT written through the lut_* bus fields.
module fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int MAX_ADDR   = 1023,
  parameter int CNT_W      = 16
) (
  input  logic     Clk,
  input  logic     Reset,
  fetch_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(MAX_ADDR);

  state_t           state;
  logic [PC_W-1:0]  pc_r;
  logic             fetch_valid_r;
  logic             done_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PC_W-1:0]  target;

  // Cycle counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // PC plus sign-extended 5-bit offset; wraps modulo 2^PC_W.
  function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] pc,
                                                 input logic [4:0] idx);
    logic signed [4:0]      off;
    logic signed [PC_W-1:0] off_ext;
    off     = $signed(idx);
    off_ext = {{(PC_W-5){off[4]}}, off};
    return pc + $unsigned(off_ext);
  endfunction

`ifdef JUMP_LUT_EN
  logic [PC_W-1:0] lut [32];

  // Target LUT: synchronous write in any state; read is combinational so a
  // same-cycle write to the index being jumped through still yields the old entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) lut[i] <= '0;
    end else if (bus.lut_we) begin
      lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  assign target = lut[bus.target_idx];
`else
  logic unused_lut;
  assign unused_lut = ^{bus.lut_we, bus.lut_waddr, bus.lut_wdata};
  assign target     = rel_target(pc_r, bus.target_idx);
`endif

  // Run-control FSM with registered PC, status flags and cycle counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      pc_r          <= START_PC;
      fetch_valid_r <= 1'b0;
      done_r        <= 1'b0;
      cnt_r         <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            state         <= RUN;
            pc_r          <= START_PC;
            cnt_r         <= '0;
            fetch_valid_r <= 1'b1;
            done_r        <= 1'b0;
          end
        end
        RUN: begin
          cnt_r <= sat_inc(cnt_r);
          if (bus.Halt) begin
            state         <= DONE;
            fetch_valid_r <= 1'b0;
            done_r        <= 1'b1;
          end else if (bus.jump_en || bus.branch_en) begin
            pc_r <= target;
          end else if (pc_r == LAST_PC) begin
            state         <= DONE;
            fetch_valid_r <= 1'b0;
            done_r        <= 1'b1;
          end else begin
            pc_r <= pc_r + PC_W'(1);
          end
        end
        default: begin
          state         <= IDLE;
          fetch_valid_r <= 1'b0;
          done_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC          = pc_r;
  assign bus.fetch_valid = fetch_valid_r;
  assign bus.Done        = done_r;
  assign bus.cycle_count = cnt_r;

endmodule
